// File: rtl/spi_responder_if.sv
// Register-port bundle between the SPI responder and the accelerator register file.
interface spi_responder_if;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    // The responder initiates accesses; the register file answers them.
    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        output reg_rdata
    );
endinterface

// File: rtl/spi_responder.sv
// SPI mode-0 slave bridging an external master onto a single-cycle 7-bit
// address / 8-bit data register port. SPI pins are oversampled in clk domain.
module spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    output logic               busy,
    output logic               frame_err,
    spi_responder_if.master    reg_bus
);

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_e;

    state_e                   state_q,     state_d;
    logic [SYNC_STAGES-1:0]   sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]   ss_sync_q,   ss_sync_d;
    logic [SYNC_STAGES-1:0]   mosi_sync_q, mosi_sync_d;
    logic                     sclk_prev_q, sclk_prev_d;
    logic                     ss_prev_q,   ss_prev_d;
    logic [CNT_W-1:0]         bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0]        rx_q,        rx_d;
    logic [DATA_W-1:0]        tx_q,        tx_d;
    logic                     miso_q,      miso_d;
    logic                     miso_oe_q,   miso_oe_d;
    logic                     busy_q,      busy_d;
    logic                     frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]        addr_q,      addr_d;
    logic [DATA_W-1:0]        wdata_q,     wdata_d;
    logic                     we_q,        we_d;
    logic                     re_q,        re_d;
    logic                     re_pend_q,   re_pend_d;
    logic [RD_LAT-1:0]        rd_pipe_q,   rd_pipe_d;

    logic                     sclk_s, ss_s, mosi_s;
    logic                     sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic                     rd_capture;
    logic [DATA_W-1:0]        tx_src;
    logic [DATA_W-1:0]        rx_byte;

    // Synchronized views of the SPI pins and their edges.
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    // Read data lands RD_LAT clocks after reg_re; a capture that coincides with
    // an sclk fall feeds the shifter directly so the first bit is never stale.
    assign rd_capture = rd_pipe_q[RD_LAT-1];
    assign tx_src     = rd_capture ? reg_bus.reg_rdata : tx_q;

    // Next-state, shifters, register-port strobes and pin outputs.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;

        rd_pipe_d[0] = re_q;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_src;
        miso_d      = miso_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        re_d        = re_pend_q;
        re_pend_d   = 1'b0;
        frame_err_d = 1'b0;
        rx_byte     = {rx_q[DATA_W-2:0], mosi_s};

        // Write address advances the clock after its strobe.
        if (we_q) begin
            addr_d = addr_q + 7'd1;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end
            end
            default: begin
                if (sclk_fall) begin
                    if (state_q == ST_RDATA) begin
                        miso_d = tx_src[DATA_W-1];
                        tx_d   = {tx_src[DATA_W-2:0], 1'b0};
                    end else begin
                        miso_d = 1'b0;
                    end
                end

                if (sclk_rise) begin
                    rx_d      = rx_byte;
                    bit_cnt_d = CNT_W'(bit_cnt_q + 3'd1);
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            ST_CMD: begin
                                addr_d = rx_byte[ADDR_W-1:0];
                                if (rx_byte[DATA_W-1]) begin
                                    state_d   = ST_RDATA;
                                    re_pend_d = 1'b1;
                                end else begin
                                    state_d = ST_WDATA;
                                end
                            end
                            ST_WDATA: begin
                                we_d    = 1'b1;
                                wdata_d = rx_byte;
                            end
                            default: begin
                                addr_d    = addr_q + 7'd1;
                                re_pend_d = 1'b1;
                            end
                        endcase
                    end
                end

                // Deselect ends the frame; a completed byte above still issues its strobe.
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                    if (bit_cnt_d != 3'd0) begin
                        frame_err_d = 1'b1;
                    end
                end
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        miso_oe_d = busy_d;
    end

    // State register with async active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            re_pend_q   <= 1'b0;
            rd_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            re_pend_q   <= re_pend_d;
            rd_pipe_q   <= rd_pipe_d;
        end
    end

    assign miso              = miso_q;
    assign miso_oe           = miso_oe_q;
    assign busy              = busy_q;
    assign frame_err         = frame_err_q;
    assign reg_bus.reg_addr  = addr_q;
    assign reg_bus.reg_wdata = wdata_q;
    assign reg_bus.reg_we    = we_q;
    assign reg_bus.reg_re    = re_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench: two responders (RD_LAT=1 and RD_LAT=2) share one SPI master.
module tb_spi_responder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sclk = 1'b0;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;

    logic miso1, oe1, busy1, ferr1;
    logic miso2, oe2, busy2, ferr2;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    spi_responder_if bus1 ();
    spi_responder_if bus2 ();

    spi_responder #(.SYNC_STAGES(2), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso1), .miso_oe(oe1), .busy(busy1), .frame_err(ferr1),
        .reg_bus(bus1.master)
    );

    spi_responder #(.SYNC_STAGES(2), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso2), .miso_oe(oe2), .busy(busy2), .frame_err(ferr2),
        .reg_bus(bus2.master)
    );

    // Register-file models: 1-cycle and 2-cycle read latency.
    logic [7:0] mem1 [128];
    logic [7:0] mem2 [128];
    logic [7:0] rd1_q, rd2a_q, rd2b_q;

    always @(posedge clk) begin
        if (bus1.reg_we) mem1[bus1.reg_addr] <= bus1.reg_wdata;
        if (bus1.reg_re) rd1_q <= mem1[bus1.reg_addr];
        if (bus2.reg_we) mem2[bus2.reg_addr] <= bus2.reg_wdata;
        if (bus2.reg_re) rd2a_q <= mem2[bus2.reg_addr];
        rd2b_q <= rd2a_q;
    end
    assign bus1.reg_rdata = rd1_q;
    assign bus2.reg_rdata = rd2b_q;

    // Strobe monitors.
    int we_cnt1 = 0, re_cnt1 = 0, fe_cnt1 = 0, clash1 = 0;
    int we_cnt2 = 0, re_cnt2 = 0, fe_cnt2 = 0, clash2 = 0;
    logic [6:0] wa1 [$];
    logic [7:0] wd1 [$];
    logic [6:0] wa2 [$];
    logic [7:0] wd2 [$];

    always @(posedge clk) begin
        if (bus1.reg_we) begin
            we_cnt1 <= we_cnt1 + 1;
            wa1.push_back(bus1.reg_addr);
            wd1.push_back(bus1.reg_wdata);
        end
        if (bus1.reg_re) re_cnt1 <= re_cnt1 + 1;
        if (ferr1) fe_cnt1 <= fe_cnt1 + 1;
        if (bus1.reg_we && bus1.reg_re) clash1 <= clash1 + 1;
        if (bus2.reg_we) begin
            we_cnt2 <= we_cnt2 + 1;
            wa2.push_back(bus2.reg_addr);
            wd2.push_back(bus2.reg_wdata);
        end
        if (bus2.reg_re) re_cnt2 <= re_cnt2 + 1;
        if (ferr2) fe_cnt2 <= fe_cnt2 + 1;
        if (bus2.reg_we && bus2.reg_re) clash2 <= clash2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input int idx, input logic [6:0] a, input logic [7:0] d);
        check("wr_addr1", (idx < wa1.size()) ? 32'(wa1[idx]) : 32'hDEAD, 32'(a));
        check("wr_data1", (idx < wd1.size()) ? 32'(wd1[idx]) : 32'hDEAD, 32'(d));
        check("wr_addr2", (idx < wa2.size()) ? 32'(wa2[idx]) : 32'hDEAD, 32'(a));
        check("wr_data2", (idx < wd2.size()) ? 32'(wd2[idx]) : 32'hDEAD, 32'(d));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy1"}, 32'(busy1), 32'd0);
        check({tag, "_oe1"},   32'(oe1),   32'd0);
        check({tag, "_busy2"}, 32'(busy2), 32'd0);
        check({tag, "_oe2"},   32'(oe2),   32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_quiet(tag);
        check({tag, "_miso1"}, 32'(miso1), 32'd0);
        check({tag, "_ferr1"}, 32'(ferr1), 32'd0);
        check({tag, "_addr1"}, 32'(bus1.reg_addr), 32'd0);
        check({tag, "_wdata1"}, 32'(bus1.reg_wdata), 32'd0);
        check({tag, "_we1"},   32'(bus1.reg_we), 32'd0);
        check({tag, "_re1"},   32'(bus1.reg_re), 32'd0);
        check({tag, "_addr2"}, 32'(bus2.reg_addr), 32'd0);
        check({tag, "_miso2"}, 32'(miso2), 32'd0);
    endtask

    // Shift nbits of tx MSB first; returns miso sampled just before each rise.
    // With end_ss, ss_n rises together with the final sclk rise.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit end_ss,
                            output logic [7:0] r1, output logic [7:0] r2);
        r1 = '0;
        r2 = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            r1[i] = miso1;
            r2[i] = miso2;
            sclk = 1'b1;
            if (end_ss && i == 0) ss_n = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic ss_begin();
        ss_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_end();
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r1, r2;
        int w0, rr0, f0;
        logic [7:0] exp_rd [4];

        // Reset values.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check_quiet("post_reset");

        // Single write 0x05 <= 0xA5.
        w0 = we_cnt1; rr0 = re_cnt1; f0 = fe_cnt1;
        ss_begin();
        check("sel_busy1", 32'(busy1), 32'd1);
        check("sel_oe1",   32'(oe1),   32'd1);
        check("sel_miso1", 32'(miso1), 32'd0);
        spi_xfer(8'h05, 8, 1'b0, r1, r2);
        check("wcmd_miso1", 32'(r1), 32'h00);
        spi_xfer(8'hA5, 8, 1'b0, r1, r2);
        ss_end();
        check("w1_cnt1", 32'(we_cnt1 - w0), 32'd1);
        check("w1_cnt2", 32'(we_cnt2 - w0), 32'd1);
        check_wr(w0, 7'h05, 8'hA5);
        check("w1_re1", 32'(re_cnt1 - rr0), 32'd0);
        check("w1_ferr1", 32'(fe_cnt1 - f0), 32'd0);
        check("w1_addr_inc", 32'(bus1.reg_addr), 32'h06);
        check_quiet("w1_end");

        // Burst write across the address wrap.
        w0 = we_cnt1;
        ss_begin();
        spi_xfer(8'h7F, 8, 1'b0, r1, r2);
        spi_xfer(8'h11, 8, 1'b0, r1, r2);
        spi_xfer(8'h22, 8, 1'b0, r1, r2);
        ss_end();
        check("wrap_cnt1", 32'(we_cnt1 - w0), 32'd2);
        check_wr(w0, 7'h7F, 8'h11);
        check_wr(w0 + 1, 7'h00, 8'h22);

        // Load 0x10/0x11 then read them back.
        ss_begin();
        spi_xfer(8'h10, 8, 1'b0, r1, r2);
        spi_xfer(8'h3C, 8, 1'b0, r1, r2);
        spi_xfer(8'hC3, 8, 1'b0, r1, r2);
        ss_end();
        w0 = we_cnt1; rr0 = re_cnt1;
        ss_begin();
        spi_xfer(8'h90, 8, 1'b0, r1, r2);
        check("rcmd_miso1", 32'(r1), 32'h00);
        check("rcmd_miso2", 32'(r2), 32'h00);
        spi_xfer(8'h00, 8, 1'b0, r1, r2);
        check("rd0_dut1", 32'(r1), 32'h3C);
        check("rd0_dut2", 32'(r2), 32'h3C);
        spi_xfer(8'h00, 8, 1'b0, r1, r2);
        check("rd1_dut1", 32'(r1), 32'hC3);
        check("rd1_dut2", 32'(r2), 32'hC3);
        ss_end();
        check("rd_re_cnt1", 32'(re_cnt1 - rr0), 32'd3);
        check("rd_re_cnt2", 32'(re_cnt2 - rr0), 32'd3);
        check("rd_we_cnt1", 32'(we_cnt1 - w0), 32'd0);

        // Abort after 3 data bits.
        w0 = we_cnt1; f0 = fe_cnt1;
        ss_begin();
        spi_xfer(8'h02, 8, 1'b0, r1, r2);
        spi_xfer(8'hE0, 3, 1'b0, r1, r2);
        ss_end();
        check("abort_ferr1", 32'(fe_cnt1 - f0), 32'd1);
        check("abort_ferr2", 32'(fe_cnt2 - f0), 32'd1);
        check("abort_we1",   32'(we_cnt1 - w0), 32'd0);
        check_quiet("abort");

        // Deselect coincident with the 8th data rise; later sclk edges ignored.
        w0 = we_cnt1; f0 = fe_cnt1;
        ss_begin();
        spi_xfer(8'h20, 8, 1'b0, r1, r2);
        spi_xfer(8'h5A, 8, 1'b1, r1, r2);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("coinc_we1", 32'(we_cnt1 - w0), 32'd1);
        check_wr(w0, 7'h20, 8'h5A);
        check("coinc_ferr1", 32'(fe_cnt1 - f0), 32'd0);
        check_quiet("coinc");

        // Async reset mid-frame, then a clean write.
        w0 = we_cnt1; f0 = fe_cnt1;
        ss_begin();
        spi_xfer(8'h03, 8, 1'b0, r1, r2);
        spi_xfer(8'hF0, 4, 1'b0, r1, r2);
        check("pre_rst_busy1", 32'(busy1), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check_quiet("held_low");
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
        ss_begin();
        spi_xfer(8'h01, 8, 1'b0, r1, r2);
        spi_xfer(8'hFF, 8, 1'b0, r1, r2);
        ss_end();
        check("rst_we1", 32'(we_cnt1 - w0), 32'd1);
        check_wr(w0, 7'h01, 8'hFF);
        check("rst_ferr1", 32'(fe_cnt1 - f0), 32'd0);

        // Max-rate 4-byte read burst from 0x7E with address wrap.
        exp_rd[0] = 8'hA1; exp_rd[1] = 8'hB2; exp_rd[2] = 8'hC4; exp_rd[3] = 8'hD8;
        ss_begin();
        spi_xfer(8'h7E, 8, 1'b0, r1, r2);
        for (int k = 0; k < 4; k++) spi_xfer(exp_rd[k], 8, 1'b0, r1, r2);
        ss_end();
        rr0 = re_cnt1;
        ss_begin();
        spi_xfer(8'hFE, 8, 1'b0, r1, r2);
        for (int k = 0; k < 4; k++) begin
            spi_xfer(8'h00, 8, 1'b0, r1, r2);
            check($sformatf("burst%0d_dut1", k), 32'(r1), 32'(exp_rd[k]));
            check($sformatf("burst%0d_dut2", k), 32'(r2), 32'(exp_rd[k]));
        end
        ss_end();
        check("burst_re1", 32'(re_cnt1 - rr0), 32'd5);
        check("burst_re2", 32'(re_cnt2 - rr0), 32'd5);

        check("clash1", 32'(clash1), 32'd0);
        check("clash2", 32'(clash2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
SPI mode-0 slave that lets an external SPI master (the SoC spi0 core or an off-board host) read and write an 8-bit register space inside the SHA-256 fabric. It oversamples SCLK/SS_n/MOSI in the system clock domain, decodes a command byte, and drives a simple single-cycle register port toward the accelerator's register file. It sits between the ARDUINO_IO SPI pins and the hash core's control/status registers.

Parameters:
SYNC_STAGES, 2, synchronizer flops on sclk, ss_n, mosi (min 2)
RD_LAT, 1, cycles from reg_re to valid reg_rdata (1 or 2)

Ports:
clk  in  1  system clock (50 MHz); SCLK must be <= clk/8
reset_n  in  1  async active-low reset
sclk  in  1  SPI clock from master, idle low (CPOL=0)
ss_n  in  1  SPI select, active low
mosi  in  1  master-out data, MSB first
miso  out  1  slave-out data, MSB first
miso_oe  out  1  1 = drive miso pin, 0 = tri-state
reg_addr  out  7  register address
reg_wdata  out  8  write data
reg_we  out  1  one-clk write strobe
reg_re  out  1  one-clk read strobe
reg_rdata  in  8  read data, valid RD_LAT clks after reg_re
busy  out  1  transaction in progress (synced ss_n low)
frame_err  out  1  one-clk pulse: ss_n rose with partial byte

Behaviour:
- Reset (async, reset_n=0): all outputs 0 (miso=0, miso_oe=0, reg_* = 0, busy=0, frame_err=0); FSM=IDLE; bit counter=0; shift regs=0.
- Inputs pass SYNC_STAGES flops; rise/fall detected from last two synced sclk samples. All logic uses synced signals only.
- Frame: byte 0 = command {rw, addr[6:0]}, rw=1 read, 0 write. Subsequent bytes = data; address auto-increments after each data byte, wraps 7'h7F -> 7'h00.
- MOSI sampled on sclk rise; MISO updated on sclk fall; MSB first. Bit counter 0..7 counts rises, wraps at 8.
- States: IDLE -> CMD on ss_n fall (bit cnt cleared, busy=1, miso_oe=1, miso=0). CMD -> WDATA (rw=0) or RDATA (rw=1) on 8th rise. Any state -> IDLE on ss_n rise (busy=0, miso_oe=0 same cycle ss_n rise is seen).
- CMD: miso outputs 0 for all 8 bits. reg_addr loaded with addr[6:0] on 8th rise.
- WDATA: on each 8th rise, next clk: reg_wdata=byte, reg_we=1 for one clk at current reg_addr; reg_addr increments the clk after reg_we.
- RDATA: one clk after entering RDATA, reg_re=1 at reg_addr; reg_rdata captured into tx shift reg exactly RD_LAT clks later; first bit driven on the first sclk fall after the command byte (by constraint, capture precedes that fall). After each 8th rise of a data byte: reg_addr++, then reg_re for prefetch of next byte; same capture rule. Prefetch on the final byte issues one extra read at frame end (registers must tolerate side-effect-free reads).
- reg_we and reg_re are never asserted in the same clk; at most one strobe per byte.
- ss_n rise with bit counter != 0: partial byte discarded, no reg_we, frame_err=1 one clk. Rise with counter=0: no error.
- ss_n rise and 8th sclk rise seen in same clk: byte completes (strobe issued) then IDLE; no frame_err.
- sclk edges while ss_n high ignored. Glitch-free: miso changes only on sclk fall or ss_n events.
- Async reset mid-frame: immediate return to reset values; next frame must begin with a new ss_n fall.

Test Plan:
- Write: ss_n low, send 8'h05, 8'hA5, ss_n high -> one reg_we with reg_addr=7'h05, reg_wdata=8'hA5; no reg_re; frame_err=0.
- Burst write wrap: cmd 8'h7F, data 8'h11, 8'h22 -> reg_we at addr 7'h7F data 8'h11, then addr 7'h00 data 8'h22.
- Read: model regs[0x10]=8'h3C, [0x11]=8'hC3; send cmd 8'h90 then 16 clocks -> miso returns 8'h3C then 8'hC3; miso=0 during cmd byte; repeat with RD_LAT=2, same result.
- Abort: cmd 8'h02, 3 data bits, ss_n high -> frame_err pulses once, no reg_we, busy=0, miso_oe=0.
- Reset mid-frame: reset_n low after 4 data bits of a write -> outputs all 0 instantly; subsequent clean write cmd 8'h01, data 8'hFF -> single reg_we addr 7'h01 data 8'hFF.
- Max rate: SCLK=clk/8, 4-byte read burst from 7'h7E -> bytes from 7'h7E, 7'h7F, 7'h00, 7'h01 correct.
